// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU/DMA memory bus arbiter.
package bus_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DMA = 1'b1;

   // The latency counter is 4 bits wide, which bounds MEM_LATENCY.
   localparam int MEM_LATENCY_MIN = 1;
   localparam int MEM_LATENCY_MAX = 15;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick with its last-grant pointer.
module rr_arb2
   import bus_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic valid0,
   input  logic valid1,
   input  logic accept,
   output logic grant0,
   output logic grant1
);
   logic last_grant;

   // On a tie the requester that did not win last time goes first.
   assign grant0 = valid0 & (~valid1 | (last_grant == REQ_DMA));
   assign grant1 = valid1 & (~valid0 | (last_grant == REQ_CPU));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last_grant <= REQ_DMA;
      else if (accept)
         last_grant <= grant1 ? REQ_DMA : REQ_CPU;
   end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the data-memory bus between the CPU MEM stage (req0) and the DMA port (req1),
// one transaction at a time, round-robin.
module mem_bus_arbiter
   import bus_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              req0_rvalid,
   output logic [DATA_W-1:0] req0_rdata,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              req1_rvalid,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              mem_re,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

   state_t     state, state_nxt;
   logic       grant0, grant1, accept;
   logic       win, lat_we;
   logic [3:0] cnt;

   rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .accept (accept),
      .grant0 (grant0),
      .grant1 (grant1)
   );

   assign accept = (state == IDLE) & (grant0 | grant1);

   always_comb begin
      state_nxt   = state;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      req0_rvalid = 1'b0;
      req1_rvalid = 1'b0;
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      case (state)
         IDLE: begin
            req0_ready = grant0;
            req1_ready = grant1;
            if (accept) state_nxt = ISSUE;
         end
         ISSUE: begin
            mem_re    = ~lat_we;
            mem_we    = lat_we;
            state_nxt = WAIT;
         end
         WAIT:
            if (cnt == 4'd0) state_nxt = RESP;
         RESP: begin
            req0_rvalid = (win == REQ_CPU);
            req1_rvalid = (win == REQ_DMA);
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         win        <= REQ_CPU;
         lat_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         req0_rdata <= '0;
         req1_rdata <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            win       <= grant1 ? REQ_DMA : REQ_CPU;
            lat_we    <= grant1 ? req1_we : req0_we;
            mem_addr  <= grant1 ? req1_addr : req0_addr;
            mem_wdata <= grant1 ? req1_wdata : req0_wdata;
         end
         if (state == ISSUE)
            cnt <= LAT_LOAD;
         else if (state == WAIT && cnt != 4'd0)
            cnt <= cnt - 4'd1;
         // Capture into the winner's register only; a write acknowledges with zero.
         if (state == WAIT && cnt == 4'd0) begin
            if (win == REQ_CPU)
               req0_rdata <= lat_we ? '0 : mem_rdata;
            else
               req1_rdata <= lat_we ? '0 : mem_rdata;
         end
      end
   end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-requester arbiter that shares the single data-memory/peripheral bus between the CPU MEM stage (requester 0) and a DMA/loader port (requester 1). It accepts one transaction at a time using round-robin arbitration. It drives the memory with a one-cycle strobe, waits a fixed read latency, then returns read data or a write acknowledgement to the winner. The CPU uses the per-requester ready/rvalid signals to stall its MEM stage.

Parameters:
ADDR_W, 32, address width of requests and memory bus
DATA_W, 32, data width
MEM_LATENCY, 1, cycles from the mem strobe to mem_rdata valid; legal range 1..15

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  CPU request pending (held until accepted)
req0_we  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  CPU address
req0_wdata  in  DATA_W  CPU write data
req0_ready  out  1  CPU request accepted this cycle
req0_rvalid  out  1  CPU transaction complete (1-cycle pulse)
req0_rdata  out  DATA_W  CPU read data, valid with req0_rvalid
req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, req1_rvalid, req1_rdata: same as above, for the DMA port
mem_re  out  1  memory read strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_re

Behaviour:
- Reset is asynchronous and active-high. It forces:
  - all outputs to 0
  - state IDLE, latency counter 0
  - round-robin pointer last_grant=1, so the CPU wins the first tie.
- A reset asserted mid-transaction abandons it; no rvalid is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - reqN_ready is combinational: high only for the chosen requester, only while in IDLE and only when its valid is high.
  - Choice when one requester is valid: that requester.
  - Choice when both are valid: the requester that is not last_grant.
  - Handshake = valid & ready in cycle T. On it: latch we/addr/wdata and the winner id, update last_grant, go to ISSUE.
  - No valid: remain in IDLE.
- ISSUE (T+1):
  - mem_re = ~we and mem_we = we, high for exactly this one cycle.
  - mem_addr and mem_wdata are driven from the latches; they hold their values until the next accept.
  - Load counter with MEM_LATENCY-1, go to WAIT.
- WAIT: decrement the counter each cycle. mem_rdata is sampled in the cycle the counter reaches 0, which is T+1+MEM_LATENCY. Then go to RESP.
- RESP (T+2+MEM_LATENCY):
  - reqW_rvalid pulses for 1 cycle, where W is the winner.
  - reqW_rdata is registered: it holds the sampled data for reads, and 0 for writes.
  - reqN_rdata holds its value until that requester's next rvalid.
  - Go to IDLE.
- Timing:
  - A new accept is possible in the cycle after RESP.
  - Throughput is one transaction per MEM_LATENCY+3 cycles.
  - ready is never high outside IDLE; requests are held off, never dropped.
- Valid deasserted before accept: no transaction, pointer unchanged.
- Both valid continuously: grants alternate 0,1,0,1...
- The non-winning requester's rvalid stays 0 throughout.
- Address and data are passed through unmodified. No width arithmetic except the 4-bit counter.

Decomposition:
- Shared package bus_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - requester id constants REQ_CPU=0, REQ_DMA=1
  - MEM_LATENCY range constants
- One natural sub-module: rr_arb2.
  - Contains the combinational 2-way round-robin pick from valid0, valid1 and last_grant.
  - Contains the last_grant register, updated on an accept strobe.

Test Plan:
- CPU read only, MEM_LATENCY=1: req0 read addr 0x40000010, memory returns 0xDEADBEEF.
  - req0_ready at T.
  - mem_re only at T+1, with mem_addr 0x40000010.
  - req0_rvalid at T+3 with rdata 0xDEADBEEF.
- DMA write only: req1 write addr 0x0000_0020, data 0x12345678.
  - mem_we one cycle with those values.
  - req1_rvalid at T+3, req1_rdata=0.
  - req0 outputs stay 0.
- Both valid from reset and held, 4 transactions.
  - Grant order CPU, DMA, CPU, DMA.
  - Accepts spaced exactly 4 cycles apart (MEM_LATENCY=1).
- MEM_LATENCY=3, CPU read.
  - mem_re at T+1, rdata sampled at T+4, rvalid at T+5.
  - ready low on both ports from T+1 to T+5.
- Reset pulse during WAIT of a DMA read.
  - All outputs are 0 next cycle and no rvalid follows.
  - After release, with both valid, the CPU is granted first.
- req0_valid pulsed for one cycle during WAIT, then dropped.
  - No accept and no mem strobe for it.
  - The pointer is unchanged; verify via the next tie.
